// File: rtl/ed25519_pkg.sv
// ed25519_pkg: widths, field constants and arbiter FSM encoding
// shared by the modular-arithmetic datapath blocks.
package ed25519_pkg;

  localparam int B        = 256;
  localparam int B2       = 2 * B;
  localparam int NREQ_DEF = 4;

  // q = 2^255 - 19, l = 2^252 + 27742317777372353535851937790883648493
  localparam logic [B-1:0] Q =
    256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [B-1:0] L =
    256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

endpackage

// File: rtl/seq_mult_256bit.sv
// seq_mult_256bit: bit-serial shift-add multiplier, one operand bit
// per cycle; done2 is a level that rises when product is final.
module seq_mult_256bit #(
  parameter int W = 256
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           start,
  input  logic           clk,
  output logic [2*W-1:0] product,
  output logic           done2
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mc_q;
  logic [W-1:0]   mp_q;
  logic [CW-1:0]  cnt_q;
  logic           done2_q;

  // No reset: the owner ignores this unit until it issues start.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_q   <= '0;
      mc_q    <= {{W{1'b0}}, a};
      mp_q    <= b;
      cnt_q   <= CW'(W);
      done2_q <= 1'b0;
    end else if (cnt_q != '0) begin
      if (mp_q[0]) acc_q <= acc_q + mc_q;
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) done2_q <= 1'b1;
    end
  end

  assign product = acc_q;
  assign done2   = done2_q;

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one sequential multiplier
// among NREQ requesters; one operation in flight at a time.
module mult_arbiter #(
  parameter  int NREQ = ed25519_pkg::NREQ_DEF,
  parameter  int B    = ed25519_pkg::B,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*B-1:0] a_in,
  input  logic [NREQ*B-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [2*B-1:0]    product,
  output logic              done_valid,
  output logic [IW-1:0]     done_id,
  output logic              busy
);

  import ed25519_pkg::*;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [B-1:0]    a_q, a_d;
  logic [B-1:0]    b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            dv_q, dv_d;
  logic [IW-1:0]   did_q, did_d;
  logic [2*B-1:0]  prod_q, prod_d;
  logic            start_q, start_d;
  logic            done2_q;

  logic [2*B-1:0]  mul_p;
  logic            done2;

  logic [IW-1:0]   win;
  logic            found;
  logic [IW-1:0]   idx;
  logic [B-1:0]    a_sel;
  logic [B-1:0]    b_sel;

  // Round-robin search from ptr_q, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        a_sel = a_in[i*B +: B];
        b_sel = b_in[i*B +: B];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    did_d   = did_q;
    prod_d  = prod_q;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_START;
          gnt_d   = NREQ'(1) << win;
          ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + IW'(1);
          id_d    = win;
          a_d     = a_sel;
          b_d     = b_sel;
          busy_d  = 1'b1;
          start_d = 1'b1;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        // Only a fresh rise of done2 belongs to this operation.
        if (done2 && !done2_q) begin
          state_d = S_RESP;
          prod_d  = mul_p;
          did_d   = id_q;
          dv_d    = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      did_q   <= '0;
      prod_q  <= '0;
      start_q <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      did_q   <= did_d;
      prod_q  <= prod_d;
      start_q <= start_d;
      done2_q <= done2;
    end
  end

  seq_mult_256bit #(
    .W(B)
  ) u_mult (
    .a      (a_q),
    .b      (b_q),
    .start  (start_q),
    .clk    (clk),
    .product(mul_p),
    .done2  (done2)
  );

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign done_valid = dv_q;
  assign done_id    = did_q;
  assign product    = prod_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed literal cases plus random traffic checked
// every cycle against a transaction-level round-robin model.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 256;
  localparam int IW = 2;
  localparam int TMO = W + 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*W-1:0]    a_in = '0;
  logic [N*W-1:0]    b_in = '0;
  logic [N-1:0]      gnt;
  logic [2*W-1:0]    product;
  logic              done_valid;
  logic [IW-1:0]     done_id;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(N), .B(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .product   (product),
    .done_valid(done_valid),
    .done_id   (done_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Transaction model: who may be granted, what product is owed.
  bit             m_idle = 1'b1;
  int             m_ptr = 0;
  logic [N-1:0]   m_gnt = '0;
  bit             m_busy = 1'b0;
  bit             inflight = 1'b0;
  int             age = 0;
  logic [2*W-1:0] m_pend = '0;
  int             m_pid = 0;
  logic [2*W-1:0] m_prod = '0;
  int             m_id = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", 512'(gnt), 512'(0));
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_dv", 512'(done_valid), 512'(0));
      chk("rst_prod", product, 512'(0));
      m_idle = 1'b1; m_ptr = 0; m_gnt = '0; m_busy = 1'b0;
      inflight = 1'b0; age = 0; m_prod = '0; m_id = 0;
    end else begin
      chk("gnt", 512'(gnt), 512'(m_gnt));
      chk("busy", 512'(busy), 512'(m_busy));
      if (inflight) age++;
      chk("dv_legal", 512'(done_valid && !(inflight && age >= 2)),
          512'(0));
      if (done_valid && inflight) begin
        m_prod = m_pend;
        m_id   = m_pid;
        inflight = 1'b0;
      end else if (inflight && age > W + 10) begin
        chk("done_timeout", 512'(age), 512'(W + 3));
        inflight = 1'b0;
      end
      chk("product", product, m_prod);
      chk("done_id", 512'(done_id), 512'(m_id));
      m_gnt = '0;
      if (done_valid) begin
        m_idle = 1'b1;
        m_busy = 1'b0;
      end else if (m_idle && req != '0) begin
        int w;
        w = rr(req, m_ptr);
        m_gnt = N'(1) << w;
        m_ptr = (w + 1) % N;
        m_pend = {256'b0, a_in[w*W +: W]} * {256'b0, b_in[w*W +: W]};
        m_pid = w;
        m_idle = 1'b0;
        m_busy = 1'b1;
        inflight = 1'b1;
        age = 0;
      end
    end
  end

  // Stimulus side
  bit             autodrop = 1'b1;
  int             ndone = 0;
  int             last_id = 0;
  bit             saw_g0 = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (done_valid) begin
      ndone++;
      last_id = int'(done_id);
    end
    if (gnt[0]) saw_g0 = 1'b1;
    if (autodrop) req = req & ~gnt;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < TMO) begin
      tick();
      if (done_valid) return;
      n++;
    end
    chk({name, "_wait"}, 512'(n), 512'(0));
  endtask

  task automatic wait_gnt(input string name);
    for (int n = 0; n < 10; n++) begin
      tick();
      if (gnt != '0) return;
    end
    chk({name, "_gnt_wait"}, 512'(0), 512'(1));
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 512'(gnt), 512'(0));
    chk("arst_busy", 512'(busy), 512'(0));
    chk("arst_dv", 512'(done_valid), 512'(0));
    chk("arst_id", 512'(done_id), 512'(0));
    chk("arst_prod", product, 512'(0));
    req = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    case ($urandom % 5)
      0: v = '1;
      1: v = W'($urandom % 16);
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [2*W-1:0] e;
    rst_n = 1'b0;
    #1;
    chk("init_busy", 512'(busy), 512'(0));
    chk("init_prod", product, 512'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single request with a wide operand
    e = 512'(54) << 255;
    set_op(0, 256'h1 << 255, 256'd54);
    req = 4'b0001;
    wait_done("r031");
    chk("r031_prod", product, e);
    chk("r031_id", 512'(done_id), 512'(0));

    // All four after reset: strict order 0..3
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 256'd10);
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_done("r032");
      chk("r032_id", 512'(done_id), 512'(k));
      chk("r032_prod", product, 512'(10 * (k + 1)));
    end

    // Rotation: after 1 is served, 2 beats 0
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 256'd100);
    req = 4'b0010;
    wait_done("r033a");
    chk("r033a_id", 512'(done_id), 512'(1));
    req = 4'b0101;
    wait_done("r033b");
    chk("r033b_id", 512'(done_id), 512'(2));
    chk("r033b_prod", product, 512'(300));
    wait_done("r033c");
    chk("r033c_id", 512'(done_id), 512'(0));
    chk("r033c_prod", product, 512'(100));

    // Reset while BUSY aborts the operation
    set_op(0, 256'd7, 256'd7);
    req = 4'b0001;
    wait_gnt("r034");
    repeat (10) tick();
    do_reset();
    ndone = 0;
    repeat (W + 15) tick();
    chk("r034_no_dv", 512'(ndone), 512'(0));
    set_op(3, 256'd3, 256'd5);
    req = 4'b1000;
    wait_done("r034b");
    chk("r034_prod", product, 512'(15));
    chk("r034_id", 512'(done_id), 512'(3));

    // req0 glitch while requester 1 is in service
    set_op(1, 256'd11, 256'd13);
    req = 4'b0010;
    wait_gnt("r035");
    ndone = 0;
    saw_g0 = 1'b0;
    repeat (5) tick();
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    repeat (W + 15) tick();
    chk("r035_ndone", 512'(ndone), 512'(1));
    chk("r035_id", 512'(last_id), 512'(1));
    chk("r035_prod", product, 512'(143));
    chk("r035_no_g0", 512'(saw_g0), 512'(0));

    // Operand change after grant
    set_op(0, 256'd7, 256'd6);
    req = 4'b0001;
    wait_gnt("r036");
    set_op(0, 256'd9, 256'd6);
    wait_done("r036");
    chk("r036_prod", product, 512'(42));

    // Random traffic, withdrawals and post-grant operand churn
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom % 6 == 0) set_op(i, rnd256(), rnd256());
          if ($urandom % 40 == 0) req[i] = 1'b1;
        end else if ($urandom % 300 == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    req = '0;
    repeat (W + 20) tick();
    chk("drain_idle", 512'(busy), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
